controlador_ram: RTL and testbench

CONTROLADOR_RAM -- requirements
Module: controlador_ram

---
 rtl/controlador_ram.sv | 146 ++++++++++++++
 tb/tb_controlador_ram.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_ram.sv
// Single-port FIFO controller over an external asynchronous RAM (depth 2^AW).
// Optional sticky overflow/underflow flag enabled by defining CTRL_RAM_ERROR_EN.
module controlador_ram #(
  parameter int ANCHO = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [ANCHO-1:0] dato_in,
  input  logic             pop,
  output logic             ocupado,
  output logic [ANCHO-1:0] dato_out,
  output logic             dato_out_valid,
  output logic             lleno,
  output logic             vacio,
  output logic [AW:0]      cuenta,
  output logic             error,
  output logic [AW-1:0]    direccion,
  output logic [ANCHO-1:0] dato_e,
  output logic             EN,
  input  logic [ANCHO-1:0] dato_s
);

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    ESCRIBE = 2'b01,
    LEE     = 2'b10,
    ENTREGA = 2'b11
  } estado_t;

  localparam logic [AW:0]   PROFUNDIDAD = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   UNO_C       = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] UNO_P       = {{(AW-1){1'b0}}, 1'b1};

  estado_t          estado_r, estado_s;
  logic [AW-1:0]    ptr_esc_r, ptr_lec_r;
  logic [AW:0]      cuenta_r;
  logic             prio_r, prio_s;      // 0: push wins the next conflict
  logic [AW-1:0]    direccion_r, direccion_s;
  logic [ANCHO-1:0] dato_e_r, dato_e_s;
  logic             en_r, en_s;
  logic [ANCHO-1:0] dato_out_r;
  logic             valid_r;
  logic             lleno_s, vacio_s, push_ok_s, pop_ok_s;

  assign lleno_s   = (cuenta_r == PROFUNDIDAD);
  assign vacio_s   = (cuenta_r == {(AW+1){1'b0}});
  assign push_ok_s = push && !lleno_s;
  assign pop_ok_s  = pop && !vacio_s;

  // Next-state and next-output selection, including push/pop arbitration
  always_comb begin
    estado_s    = estado_r;
    direccion_s = direccion_r;
    dato_e_s    = dato_e_r;
    en_s        = 1'b0;
    prio_s      = prio_r;
    case (estado_r)
      REPOSO: begin
        if (push_ok_s && (!pop_ok_s || !prio_r)) begin
          estado_s    = ESCRIBE;
          direccion_s = ptr_esc_r;
          dato_e_s    = dato_in;
          en_s        = 1'b1;
          prio_s      = pop_ok_s ? 1'b1 : prio_r;
        end else if (pop_ok_s) begin
          estado_s    = LEE;
          direccion_s = ptr_lec_r;
          prio_s      = push_ok_s ? 1'b0 : prio_r;
        end else begin
          estado_s    = REPOSO;
        end
      end
      ESCRIBE: estado_s = REPOSO;
      LEE:     estado_s = ENTREGA;
      ENTREGA: estado_s = REPOSO;
      default: estado_s = REPOSO;
    endcase
  end

  // State, RAM-side outputs, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r    <= REPOSO;
      ptr_esc_r   <= {AW{1'b0}};
      ptr_lec_r   <= {AW{1'b0}};
      cuenta_r    <= {(AW+1){1'b0}};
      prio_r      <= 1'b0;
      direccion_r <= {AW{1'b0}};
      dato_e_r    <= {ANCHO{1'b0}};
      en_r        <= 1'b0;
      dato_out_r  <= {ANCHO{1'b0}};
      valid_r     <= 1'b0;
    end else begin
      estado_r    <= estado_s;
      direccion_r <= direccion_s;
      dato_e_r    <= dato_e_s;
      en_r        <= en_s;
      prio_r      <= prio_s;
      valid_r     <= (estado_r == LEE);
      if (estado_r == LEE) begin
        dato_out_r <= dato_s;
      end
      // Pointer and count updates commit only when the transfer completes
      if (estado_r == ESCRIBE) begin
        ptr_esc_r <= ptr_esc_r + UNO_P;
        cuenta_r  <= cuenta_r + UNO_C;
      end else if (estado_r == ENTREGA) begin
        ptr_lec_r <= ptr_lec_r + UNO_P;
        cuenta_r  <= cuenta_r - UNO_C;
      end
    end
  end

`ifdef CTRL_RAM_ERROR_EN
  logic error_r;
  logic drop_s;

  assign drop_s = (estado_r == REPOSO) && ((push && lleno_s) || (pop && vacio_s));

  // Sticky flag for any request dropped on a full or empty FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r <= 1'b0;
    end else if (drop_s) begin
      error_r <= 1'b1;
    end
  end

  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  assign ocupado        = (estado_r != REPOSO);
  assign dato_out       = dato_out_r;
  assign dato_out_valid = valid_r;
  assign lleno          = lleno_s;
  assign vacio          = vacio_s;
  assign cuenta         = cuenta_r;
  assign direccion      = direccion_r;
  assign dato_e         = dato_e_r;
  assign EN             = en_r;

endmodule

// File: tb/tb_controlador_ram.sv
// Self-checking bench for controlador_ram: queue-based FIFO reference model plus
// a behavioural asynchronous RAM; randomized and directed scenarios.
module tb_controlador_ram;
  localparam int PROF = 256;

  logic       clk, rst_n, push, pop;
  logic [7:0] dato_in, dato_out, direccion, dato_e, dato_s;
  logic       ocupado, dato_out_valid, lleno, vacio, error, EN;
  logic [8:0] cuenta;
  logic [7:0] mem [PROF];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] q[$];
  int  wptr_m, rptr_m;
  bit  prio_m, err_m;

  controlador_ram #(.ANCHO(8), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .dato_in(dato_in), .pop(pop),
    .ocupado(ocupado), .dato_out(dato_out), .dato_out_valid(dato_out_valid),
    .lleno(lleno), .vacio(vacio), .cuenta(cuenta), .error(error),
    .direccion(direccion), .dato_e(dato_e), .EN(EN), .dato_s(dato_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dato_s = mem[direccion];
  always @(posedge clk) if (EN) mem[direccion] <= dato_e;

  function automatic bit exp_error();
`ifdef CTRL_RAM_ERROR_EN
    return err_m;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    q.delete();
    wptr_m = 0; rptr_m = 0; prio_m = 1'b0; err_m = 1'b0;
  endfunction

  // 0 = nothing, 1 = write, 2 = read
  function automatic int model_kind(input bit p, input bit r);
    bit pw, rd;
    pw = p && (q.size() < PROF);
    rd = r && (q.size() > 0);
    if ((p && q.size() == PROF) || (r && q.size() == 0)) err_m = 1'b1;
    if (pw && rd) begin
      prio_m = !prio_m;
      return prio_m ? 1 : 2;
    end
    if (pw) return 1;
    if (rd) return 2;
    return 0;
  endfunction

  task automatic apply_reset();
    push = 1'b0; pop = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  // One request issued from REPOSO; returns what the DUT did and its strobe pattern
  task automatic cycle_req(input bit p, input bit r, input logic [7:0] d, output int kind,
                           output logic [7:0] addr, output logic [7:0] data, output logic [2:0] pat);
    int budget;
    budget = 0; kind = 0; addr = 8'd0; data = 8'd0; pat = 3'b000;
    while (ocupado && budget < 20) begin @(negedge clk); budget++; end
    checks++;
    if (ocupado) begin errors++; $display("FAIL idle_wait: ocupado still 1 after %0d cycles, required 0", budget); end
    push = p; pop = r; dato_in = d;
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    if (EN) begin
      kind = 1; addr = direccion; data = dato_e; pat[2] = 1'b1;
      @(negedge clk); pat[1] = EN;
    end else if (ocupado) begin
      kind = 2; addr = direccion; pat[2] = dato_out_valid;
      @(negedge clk); pat[1] = dato_out_valid; data = dato_out;
      @(negedge clk); pat[0] = dato_out_valid;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", EN); end
    checks++; if (direccion !== 8'd0) begin errors++; $display("FAIL reset_dir: got %0d want 0", direccion); end
    checks++; if (cuenta !== 9'd0) begin errors++; $display("FAIL reset_cuenta: got %0d want 0", cuenta); end
    checks++; if (vacio !== 1'b1 || lleno !== 1'b0) begin errors++; $display("FAIL reset_flags: vacio %0b lleno %0b want 1 0", vacio, lleno); end
    checks++; if (dato_out_valid !== 1'b0 || dato_out !== 8'd0) begin errors++; $display("FAIL reset_out: valid %0b dato %0d want 0 0", dato_out_valid, dato_out); end
    checks++; if (error !== 1'b0 || ocupado !== 1'b0) begin errors++; $display("FAIL reset_misc: error %0b ocupado %0b want 0 0", error, ocupado); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_push_pop();
    logic [7:0] vals [3];
    logic [7:0] a, d, e;
    logic [2:0] pat;
    int k;
    vals[0] = 8'd64; vals[1] = 8'd25; vals[2] = 8'd55;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      void'(model_kind(1'b1, 1'b0));
      cycle_req(1'b1, 1'b0, vals[i], k, a, d, pat);
      q.push_back(vals[i]);
      checks++;
      if (k !== 1 || a !== 8'(i) || d !== vals[i] || pat !== 3'b100)
        begin errors++; $display("FAIL push_%0d: kind %0d dir %0d dato_e %0d pat %b want 1 %0d %0d 100", i, k, a, d, pat, i, vals[i]); end
    end
    checks++; if (cuenta !== 9'd3) begin errors++; $display("FAIL push_cuenta: got %0d want 3", cuenta); end
    for (int i = 0; i < 3; i++) begin
      void'(model_kind(1'b0, 1'b1));
      cycle_req(1'b0, 1'b1, 8'd0, k, a, d, pat);
      e = q.pop_front();
      checks++;
      if (k !== 2 || a !== 8'(i) || d !== e || pat !== 3'b010)
        begin errors++; $display("FAIL pop_%0d: kind %0d dir %0d dato %0d pat %b want 2 %0d %0d 010", i, k, a, d, pat, i, e); end
    end
    checks++; if (vacio !== 1'b1 || cuenta !== 9'd0) begin errors++; $display("FAIL pop_vacio: vacio %0b cuenta %0d want 1 0", vacio, cuenta); end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] a, d, v, e;
    logic [2:0] pat;
    int k, bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < PROF; i++) begin
      v = 8'($urandom);
      void'(model_kind(1'b1, 1'b0));
      cycle_req(1'b1, 1'b0, v, k, a, d, pat);
      q.push_back(v);
      if (k !== 1 || a !== 8'(i) || d !== v) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_writes: %0d bad writes, want 0", bad); end
    checks++; if (lleno !== 1'b1 || cuenta !== 9'd256) begin errors++; $display("FAIL fill_lleno: lleno %0b cuenta %0d want 1 256", lleno, cuenta); end
    k = model_kind(1'b1, 1'b0);
    cycle_req(1'b1, 1'b0, 8'hA5, k, a, d, pat);
    checks++; if (k !== 0 || cuenta !== 9'd256) begin errors++; $display("FAIL drop_push: kind %0d cuenta %0d want 0 256", k, cuenta); end
    checks++; if (error !== exp_error()) begin errors++; $display("FAIL drop_error: got %0b want %0b", error, exp_error()); end
    void'(model_kind(1'b0, 1'b1));
    cycle_req(1'b0, 1'b1, 8'd0, k, a, d, pat);
    e = q.pop_front();
    checks++; if (k !== 2 || a !== 8'd0 || d !== e) begin errors++; $display("FAIL full_pop: kind %0d dir %0d dato %0d want 2 0 %0d", k, a, d, e); end
    void'(model_kind(1'b1, 1'b0));
    cycle_req(1'b1, 1'b0, 8'h3C, k, a, d, pat);
    q.push_back(8'h3C);
    checks++; if (k !== 1 || a !== 8'd0 || d !== 8'h3C) begin errors++; $display("FAIL wrap_push: kind %0d dir %0d dato %0d want 1 0 60", k, a, d); end
  endtask

  task automatic test_alternate();
    logic [7:0] a, d, e;
    logic [2:0] pat;
    int k, n, budget, wr_addr, rd_addr;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      void'(model_kind(1'b1, 1'b0));
      cycle_req(1'b1, 1'b0, 8'(10 + i), k, a, d, pat);
      q.push_back(8'(10 + i));
    end
    checks++; if (cuenta !== 9'd2) begin errors++; $display("FAIL alt_start: cuenta %0d want 2", cuenta); end
    wr_addr = 2; rd_addr = 0; n = 0; budget = 0;
    push = 1'b1; pop = 1'b1; dato_in = 8'($urandom);
    while (n < 4 && budget < 60) begin
      @(negedge clk); budget++;
      if (EN || dato_out_valid) begin
        k = model_kind(1'b1, 1'b1);
        checks++;
        if (EN) begin
          if (k !== 1 || direccion !== 8'(wr_addr) || dato_e !== dato_in)
            begin errors++; $display("FAIL alt_event_%0d: write at %0d, model kind %0d want dir %0d", n, direccion, k, wr_addr); end
          q.push_back(dato_e); wr_addr++;
          dato_in = 8'($urandom);
        end else begin
          e = q.pop_front();
          if (k !== 2 || dato_out !== e)
            begin errors++; $display("FAIL alt_event_%0d: read %0d, model kind %0d want dato %0d", n, dato_out, k, e); end
          rd_addr++;
        end
        n++;
      end
    end
    push = 1'b0; pop = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL alt_timeout: %0d events seen, want 4", n); end
    @(negedge clk);
    checks++; if (cuenta !== 9'(q.size())) begin errors++; $display("FAIL alt_cuenta: got %0d want %0d", cuenta, q.size()); end
  endtask

  task automatic test_reset_in_write();
    logic [7:0] a, d;
    logic [2:0] pat;
    int k;
    apply_reset();
    for (int i = 0; i < 8; i++) cycle_req(1'b1, 1'b0, 8'(i), k, a, d, pat);
    push = 1'b1; dato_in = 8'd87;
    @(negedge clk); push = 1'b0;
    checks++; if (EN !== 1'b1 || direccion !== 8'd8) begin errors++; $display("FAIL rstw_setup: EN %0b dir %0d want 1 8", EN, direccion); end
    rst_n = 1'b0; #1;
    checks++; if (EN !== 1'b0 || cuenta !== 9'd0 || vacio !== 1'b1)
      begin errors++; $display("FAIL rstw_drop: EN %0b cuenta %0d vacio %0b want 0 0 1", EN, cuenta, vacio); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    cycle_req(1'b1, 1'b0, 8'd9, k, a, d, pat);
    checks++; if (k !== 1 || a !== 8'd0) begin errors++; $display("FAIL rstw_after: kind %0d dir %0d want 1 0", k, a); end
  endtask

  task automatic test_random();
    logic [7:0] a, d, v, e;
    logic [2:0] pat;
    int k, ek, exp_addr;
    bit p, r;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      p = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      v = 8'($urandom);
      ek = model_kind(p, r);
      exp_addr = (ek == 1) ? wptr_m : rptr_m;
      cycle_req(p, r, v, k, a, d, pat);
      e = 8'd0;
      if (ek == 1) begin q.push_back(v); e = v; wptr_m = (wptr_m + 1) % PROF; end
      if (ek == 2) begin e = q.pop_front(); rptr_m = (rptr_m + 1) % PROF; end
      checks++;
      if (k !== ek || (ek != 0 && (a !== 8'(exp_addr) || d !== e)) ||
          (ek == 1 && pat !== 3'b100) || (ek == 2 && pat !== 3'b010))
        begin errors++; $display("FAIL rand_%0d: kind %0d dir %0d dato %0d pat %b want %0d %0d %0d", i, k, a, d, pat, ek, exp_addr, e); end
    end
    checks++; if (cuenta !== 9'(q.size())) begin errors++; $display("FAIL rand_cuenta: got %0d want %0d", cuenta, q.size()); end
    checks++; if (error !== exp_error()) begin errors++; $display("FAIL rand_error: got %0b want %0b", error, exp_error()); end
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; dato_in = 8'd0;
    for (int i = 0; i < PROF; i++) mem[i] = 8'd0;
    model_reset();
    test_reset();
    test_push_pop();
    test_fill_wrap();
    test_alternate();
    test_reset_in_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
